// File: rtl/sequence_frame_checker_if.sv
// Bundle of the serial input, counter clear and result signals of the
// frame checker. The master side drives the line; the slave side is the checker.
interface sequence_frame_checker_if #(
  parameter int LEN   = 6,
  parameter int CNT_W = 8
);
  logic             din;
  logic             clr_cnt;
  logic             busy;
  logic             frame_ok;
  logic             frame_err;
  logic [LEN-1:0]   last_frame;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output din, clr_cnt,
    input  busy, frame_ok, frame_err, last_frame, ok_cnt, err_cnt
  );

  modport slave (
    input  din, clr_cnt,
    output busy, frame_ok, frame_err, last_frame, ok_cnt, err_cnt
  );
endinterface

// File: rtl/sequence_frame_checker.sv
// Serial frame checker: collects LEN-bit bursts that begin with a 1 and
// compares each against PATTERN, with pass/fail pulses and saturating counters.
module sequence_frame_checker #(
  parameter int             LEN     = 6,
  parameter logic [LEN-1:0] PATTERN = LEN'(6'b100011),
  parameter int             CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  sequence_frame_checker_if.slave  bus
);
  localparam int IDX_W = (LEN > 2) ? $clog2(LEN) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           r_state;
  // Only the LEN-1 bits before the current one need storing; the final bit
  // is taken straight from din on the completion edge.
  logic [LEN-2:0]   r_sr;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [LEN-1:0]   r_last_frame;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [LEN-1:0]   w_frame;
  logic             w_done;
  logic             w_match;

  assign w_frame = {r_sr, bus.din};
  assign w_done  = (r_state == RECV) && (r_idx == IDX_W'(LEN - 1));
  assign w_match = (w_frame == PATTERN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_last_frame <= '0;
      r_ok_cnt     <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.din) begin
            r_sr    <= (LEN-1)'(1);
            r_idx   <= IDX_W'(1);
            r_state <= RECV;
            r_busy  <= 1'b1;
          end
        end
        RECV: begin
          r_sr  <= w_frame[LEN-2:0];
          r_idx <= r_idx + IDX_W'(1);
          if (w_done) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_last_frame <= w_frame;
            r_frame_ok   <= w_match;
            r_frame_err  <= !w_match;
            if (w_match) begin
              if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end else begin
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      // Placed last so a clear wins over an increment on the same edge.
      if (bus.clr_cnt) begin
        r_ok_cnt  <= '0;
        r_err_cnt <= '0;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.frame_ok   = r_frame_ok;
  assign bus.frame_err  = r_frame_err;
  assign bus.last_frame = r_last_frame;
  assign bus.ok_cnt     = r_ok_cnt;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_sequence_frame_checker.sv
// Bench for sequence_frame_checker: two instances (CNT_W 8 and 2) share one
// serial stream and are compared each cycle against a frame-level model.
module tb_sequence_frame_checker;
  localparam int             LEN = 6;
  localparam logic [LEN-1:0] PAT = 6'b100011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic clr_cnt = 1'b0;

  int checks = 0;
  int errors = 0;

  sequence_frame_checker_if #(.LEN(LEN), .CNT_W(8)) bus_a ();
  sequence_frame_checker_if #(.LEN(LEN), .CNT_W(2)) bus_b ();

  assign bus_a.din     = din;
  assign bus_a.clr_cnt = clr_cnt;
  assign bus_b.din     = din;
  assign bus_b.clr_cnt = clr_cnt;

  sequence_frame_checker #(.LEN(LEN), .PATTERN(PAT), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  sequence_frame_checker #(.LEN(LEN), .PATTERN(PAT), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is "the 1 that starts it plus the next LEN-1 samples".
  bit          m_started = 0;
  bit          m_inframe;
  int          m_nbits;
  logic [15:0] m_acc;
  bit          m_ok, m_err;
  logic [15:0] m_last;
  int          m_okc [2];
  int          m_errc [2];
  int          m_max [2] = '{255, 3};

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1;
      m_inframe = 0;
      m_nbits   = 0;
      m_acc     = '0;
      m_ok      = 0;
      m_err     = 0;
      m_last    = '0;
      for (int unsigned i = 0; i < 2; i++) begin
        m_okc[i]  = 0;
        m_errc[i] = 0;
      end
    end else begin
      m_ok  = 0;
      m_err = 0;
      if (m_inframe) begin
        m_acc   = (m_acc << 1) | 16'(din);
        m_nbits = m_nbits + 1;
        if (m_nbits == LEN) begin
          m_inframe = 0;
          m_last    = m_acc;
          m_ok      = (m_acc == 16'(PAT));
          m_err     = !m_ok;
          for (int unsigned i = 0; i < 2; i++) begin
            if (m_ok && m_okc[i] < m_max[i]) m_okc[i]++;
            if (m_err && m_errc[i] < m_max[i]) m_errc[i]++;
          end
        end
      end else if (din) begin
        m_inframe = 1;
        m_acc     = 16'd1;
        m_nbits   = 1;
      end
      if (clr_cnt) begin
        for (int unsigned i = 0; i < 2; i++) begin
          m_okc[i]  = 0;
          m_errc[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("a_busy", 16'(bus_a.busy), 16'(m_inframe));
      chk("a_ok", 16'(bus_a.frame_ok), 16'(m_ok));
      chk("a_err", 16'(bus_a.frame_err), 16'(m_err));
      chk("a_last", 16'(bus_a.last_frame), m_last);
      chk("a_okcnt", 16'(bus_a.ok_cnt), 16'(m_okc[0]));
      chk("a_errcnt", 16'(bus_a.err_cnt), 16'(m_errc[0]));
      chk("b_busy", 16'(bus_b.busy), 16'(m_inframe));
      chk("b_ok", 16'(bus_b.frame_ok), 16'(m_ok));
      chk("b_err", 16'(bus_b.frame_err), 16'(m_err));
      chk("b_last", 16'(bus_b.last_frame), m_last);
      chk("b_okcnt", 16'(bus_b.ok_cnt), 16'(m_okc[1]));
      chk("b_errcnt", 16'(bus_b.err_cnt), 16'(m_errc[1]));
    end
  end

  // Drive one sample, then return at the next negedge with outputs settled.
  task automatic step(input logic d, input logic c, input logic r);
    din = d;
    clr_cnt = c;
    reset = r;
    @(negedge clk);
  endtask

  task automatic send(input logic [LEN-1:0] f);
    for (int i = LEN - 1; i >= 0; i--) step(f[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [LEN-1:0] f;
    int r;
    @(negedge clk);

    // Single good frame after a 3-cycle reset.
    do_reset(3);
    chk("rst_last", 16'(bus_a.last_frame), 16'h0);
    chk("rst_okcnt", 16'(bus_a.ok_cnt), 16'h0);
    send(PAT);
    chk("t1_ok", 16'(bus_a.frame_ok), 16'h1);
    chk("t1_err", 16'(bus_a.frame_err), 16'h0);
    chk("t1_okcnt", 16'(bus_a.ok_cnt), 16'h1);
    chk("t1_last", 16'(bus_a.last_frame), 16'h23);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_pulse_end", 16'(bus_a.frame_ok), 16'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Two back-to-back good frames.
    do_reset(1);
    send(PAT);
    chk("t2_ok1", 16'(bus_a.frame_ok), 16'h1);
    step(1'b1, 1'b0, 1'b0);
    chk("t2_busy_new", 16'(bus_a.busy), 16'h1);
    chk("t2_pulse_end", 16'(bus_a.frame_ok), 16'h0);
    for (int i = LEN - 2; i >= 0; i--) step(PAT[i], 1'b0, 1'b0);
    chk("t2_ok2", 16'(bus_a.frame_ok), 16'h1);
    chk("t2_okcnt", 16'(bus_a.ok_cnt), 16'h2);
    step(1'b0, 1'b0, 1'b0);

    // Mismatching frame.
    do_reset(1);
    send(6'b101011);
    chk("t3_err", 16'(bus_a.frame_err), 16'h1);
    chk("t3_errcnt", 16'(bus_a.err_cnt), 16'h1);
    chk("t3_okcnt", 16'(bus_a.ok_cnt), 16'h0);
    chk("t3_last", 16'(bus_a.last_frame), 16'h2b);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset(1);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk("t4_busy", 16'(bus_a.busy), 16'h0);
    chk("t4_last", 16'(bus_a.last_frame), 16'h0);
    chk("t4_errcnt", 16'(bus_a.err_cnt), 16'h0);

    // Saturation of the narrow counter, then clear coinciding with an increment.
    do_reset(1);
    repeat (5) send(PAT);
    chk("t5_b_sat", 16'(bus_b.ok_cnt), 16'h3);
    chk("t5_a_cnt", 16'(bus_a.ok_cnt), 16'h5);
    for (int i = LEN - 1; i >= 1; i--) step(PAT[i], 1'b0, 1'b0);
    step(PAT[0], 1'b1, 1'b0);
    chk("t5_ok_pulse", 16'(bus_b.frame_ok), 16'h1);
    chk("t5_b_clr", 16'(bus_b.ok_cnt), 16'h0);
    chk("t5_a_clr", 16'(bus_a.ok_cnt), 16'h0);
    step(1'b0, 1'b0, 1'b0);

    // Random mix of good frames, random bits, idle gaps, clears and resets.
    do_reset(1);
    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        send(PAT);
      end else if (r < 16) begin
        f = LEN'($urandom);
        for (int i = LEN - 1; i >= 0; i--)
          step(f[i], 1'($urandom_range(0, 29) == 0), 1'b0);
      end else if (r < 19) begin
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0);
      end else begin
        step(1'($urandom), 1'b0, 1'b1);
      end
    end
    repeat (LEN + 2) step(1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
